regfile_scoreboard: RTL and testbench

// - Parametrised successor register file for the ECE350 pipeline: DEPTH x DATA_W storage, N_READ async read ports, one write port.
// - Adds same-cycle write->read bypass and a per-register busy scoreboard (set at issue, cleared at writeback).
// - Sits between decode (reads, issue) and writeback; issue_stall feeds the pipeline hazard/stall logic.

---
 rtl/rf_pkg.sv | 10 +
 rtl/rf_read_port.sv | 37 +++
 rtl/regfile_scoreboard.sv | 106 ++++++++++
 tb/tb_regfile_scoreboard.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared defaults and index helpers for the scoreboarded register file.
package rf_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned REG_ZERO   = 0;

  typedef logic [ADDR_W_DEF-1:0] reg_idx_t;

endpackage

// File: rtl/rf_read_port.sv
// One asynchronous read port: zero-register masking, write bypass and busy qualification.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned BYPASS = 1
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] stored,
  input  logic              stored_busy,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] data,
  output logic              busy
);

  logic nonzero;
  logic fwd;

  assign nonzero = (addr != ADDR_W'(REG_ZERO));
  assign fwd     = (BYPASS != 0) && write_enable && (write_reg == addr) && nonzero;

  always_comb begin
    data = stored;
    if (!nonzero) begin
      data = '0;
    end else if (fwd) begin
      data = write_data;
    end
  end

  // A forwarded writeback already satisfies the pending write for this reader.
  assign busy = stored_busy && nonzero && !fwd;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with same-cycle write bypass and a per-register busy scoreboard
// (reserved at issue, released at writeback) plus a count of pending registers.
module regfile_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned N_READ    = 2,
  parameter int unsigned BYPASS    = 1,
  parameter int unsigned DEBUG_REG = 3
) (
  input  logic                     clock,
  input  logic                     ctrl_reset,
  input  logic                     ctrl_writeEnable,
  input  logic [ADDR_W-1:0]        ctrl_writeReg,
  input  logic [DATA_W-1:0]        data_writeReg,
  input  logic [N_READ*ADDR_W-1:0] ctrl_readReg,
  output logic [N_READ*DATA_W-1:0] data_readReg,
  output logic [N_READ-1:0]        read_busy,
  input  logic                     ctrl_issueEnable,
  input  logic [ADDR_W-1:0]        ctrl_issueReg,
  output logic                     issue_stall,
  output logic [ADDR_W:0]          pending_count,
  output logic [DATA_W-1:0]        debugOut
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [ADDR_W:0]   count;

  logic wr_ok;
  logic is_ok;
  logic same_reg;
  logic set_busy;
  logic inc;
  logic dec;

  assign wr_ok    = ctrl_writeEnable && (ctrl_writeReg != ADDR_W'(REG_ZERO));
  assign is_ok    = ctrl_issueEnable && (ctrl_issueReg != ADDR_W'(REG_ZERO));
  assign same_reg = wr_ok && (ctrl_writeReg == ctrl_issueReg);

  // WAW hazard unless the pending write retires in this very cycle.
  assign issue_stall = is_ok && busy[ctrl_issueReg] && !same_reg;
  assign set_busy    = is_ok && !issue_stall;

  // Re-issue of a register retiring this cycle leaves the count unchanged.
  assign inc = set_busy && !busy[ctrl_issueReg];
  assign dec = wr_ok && busy[ctrl_writeReg] && !(set_busy && same_reg);

  // Storage; index 0 is never written and stays at its reset value.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[ctrl_writeReg] <= data_writeReg;
    end
  end

  // Scoreboard: clear at writeback, then set at issue so set wins on a collision.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      busy  <= '0;
      count <= '0;
    end else begin
      if (wr_ok) begin
        busy[ctrl_writeReg] <= 1'b0;
      end
      if (set_busy) begin
        busy[ctrl_issueReg] <= 1'b1;
      end
      if (inc && !dec) begin
        count <= count + (ADDR_W+1)'(1);
      end else if (dec && !inc) begin
        count <= count - (ADDR_W+1)'(1);
      end
    end
  end

  assign pending_count = count;
  assign debugOut      = regs[ADDR_W'(DEBUG_REG)];

  for (genvar g = 0; g < int'(N_READ); g++) begin : g_read
    logic [ADDR_W-1:0] addr;
    assign addr = ctrl_readReg[g*ADDR_W +: ADDR_W];

    rf_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .BYPASS (BYPASS)
    ) u_port (
      .addr         (addr),
      .stored       (regs[addr]),
      .stored_busy  (busy[addr]),
      .write_enable (ctrl_writeEnable),
      .write_reg    (ctrl_writeReg),
      .write_data   (data_writeReg),
      .data         (data_readReg[g*DATA_W +: DATA_W]),
      .busy         (read_busy[g])
    );
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench: directed scenarios plus random traffic against an array-based model,
// run on a bypassing and a non-bypassing instance sharing the same stimulus.
module tb_regfile_scoreboard;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic          clock = 1'b0;
  logic          ctrl_reset;
  logic          we;
  logic [AW-1:0] wr;
  logic [DW-1:0] wd;
  logic [AW-1:0] ra [NR];
  logic          ie;
  logic [AW-1:0] ir;

  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rd   [2];
  logic [NR-1:0]    rbsy [2];
  logic             stl  [2];
  logic [AW:0]      cnt  [2];
  logic [DW-1:0]    dbg  [2];

  int n_pass  = 0;
  int n_total = 0;

  logic [DW-1:0] m_regs [32];
  bit            m_busy [32];

  assign raddr = {ra[1], ra[0]};

  always #5 clock = ~clock;

  regfile_scoreboard #(.BYPASS(1)) dut_byp (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .ctrl_writeEnable(we), .ctrl_writeReg(wr), .data_writeReg(wd),
    .ctrl_readReg(raddr), .data_readReg(rd[0]), .read_busy(rbsy[0]),
    .ctrl_issueEnable(ie), .ctrl_issueReg(ir), .issue_stall(stl[0]),
    .pending_count(cnt[0]), .debugOut(dbg[0])
  );

  regfile_scoreboard #(.BYPASS(0)) dut_nob (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .ctrl_writeEnable(we), .ctrl_writeReg(wr), .data_writeReg(wd),
    .ctrl_readReg(raddr), .data_readReg(rd[1]), .read_busy(rbsy[1]),
    .ctrl_issueEnable(ie), .ctrl_issueReg(ir), .issue_stall(stl[1]),
    .pending_count(cnt[1]), .debugOut(dbg[1])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
  endtask

  function automatic int model_count();
    int c = 0;
    for (int r = 0; r < 32; r++) c += int'(m_busy[r]);
    return c;
  endfunction

  function automatic void model_reset();
    for (int r = 0; r < 32; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
  endfunction

  // Combinational outputs of both instances against the model for the current inputs.
  task automatic check_comb();
    for (int d = 0; d < 2; d++) begin
      bit byp = (d == 0);
      bit stall_e = ie && ir != 0 && m_busy[ir] && !(we && wr == ir);
      check($sformatf("stall%0d", d), 64'(stl[d]), 64'(stall_e));
      for (int p = 0; p < NR; p++) begin
        bit fwd = byp && we && wr == ra[p] && ra[p] != 0;
        logic [DW-1:0] exp_d = (ra[p] == 0) ? '0 : (fwd ? wd : m_regs[ra[p]]);
        bit exp_b = m_busy[ra[p]] && !fwd;
        check($sformatf("rd%0d_p%0d", d, p), 64'(rd[d][p*DW +: DW]), 64'(exp_d));
        check($sformatf("rbusy%0d_p%0d", d, p), 64'(rbsy[d][p]), 64'(exp_b));
      end
    end
  endtask

  task automatic check_state();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("count%0d", d), 64'(cnt[d]), 64'(model_count()));
      check($sformatf("debug%0d", d), 64'(dbg[d]), 64'(m_regs[3]));
    end
  endtask

  task automatic apply(input bit w_en, input int w_reg, input logic [DW-1:0] w_dat,
                       input int r0, input int r1, input bit i_en, input int i_reg);
    we = w_en; wr = AW'(w_reg); wd = w_dat;
    ra[0] = AW'(r0); ra[1] = AW'(r1);
    ie = i_en; ir = AW'(i_reg);
    #1;
    check_comb();
  endtask

  // Clock edge: advance the model with the inputs held across it.
  task automatic tick();
    bit stall_e;
    @(posedge clock);
    stall_e = ie && ir != 0 && m_busy[ir] && !(we && wr == ir);
    if (we && wr != 0) begin
      m_regs[wr] = wd;
      m_busy[wr] = 1'b0;
    end
    if (ie && ir != 0 && !stall_e) m_busy[ir] = 1'b1;
    #1;
    check_state();
  endtask

  initial begin
    model_reset();
    ctrl_reset = 1'b1;
    we = 0; wr = '0; wd = '0; ra[0] = '0; ra[1] = '0; ie = 0; ir = '0;
    #12;
    apply(0, 0, 0, 5, 9, 0, 0);
    check("rst_rd", 64'(rd[0]), 64'(0));
    check("rst_busy", 64'(rbsy[0]), 64'(0));
    check("rst_count", 64'(cnt[0]), 64'(0));
    check("rst_debug", 64'(dbg[0]), 64'(0));
    check("rst_stall", 64'(stl[0]), 64'(0));
    ctrl_reset = 1'b0;
    @(negedge clock);

    // write then read on both ports; r0 writes ignored
    apply(1, 5, 32'hDEADBEEF, 0, 0, 0, 0); tick();
    apply(0, 0, 0, 5, 5, 0, 0);
    check("r5_p0", 64'(rd[0][31:0]), 64'hDEADBEEF);
    check("r5_p1", 64'(rd[0][63:32]), 64'hDEADBEEF);
    apply(1, 0, 32'h1234, 0, 0, 0, 0); tick();
    apply(0, 0, 0, 0, 5, 0, 0);
    check("r0_read", 64'(rd[0][31:0]), 64'(0));

    // bypass vs no bypass
    apply(1, 7, 32'hA5A5A5A5, 7, 7, 0, 0);
    check("byp_r7", 64'(rd[0][31:0]), 64'hA5A5A5A5);
    check("nobyp_r7", 64'(rd[1][31:0]), 64'(0));
    tick();
    apply(0, 0, 0, 7, 7, 0, 0);
    check("nobyp_r7_next", 64'(rd[1][31:0]), 64'hA5A5A5A5);

    // issue, WAW stall, writeback
    apply(0, 0, 0, 9, 9, 1, 9); tick();
    check("r9_count1", 64'(cnt[0]), 64'(1));
    apply(0, 0, 0, 9, 0, 1, 9);
    check("r9_busy", 64'(rbsy[0][0]), 64'(1));
    check("r9_stall", 64'(stl[0]), 64'(1));
    tick();
    check("r9_count_hold", 64'(cnt[0]), 64'(1));
    apply(1, 9, 32'h99, 9, 9, 0, 0);
    check("nobyp_wb_busy", 64'(rbsy[1][0]), 64'(1));
    tick();
    apply(0, 0, 0, 9, 9, 0, 0);
    check("r9_cleared", 64'(rbsy[0][0]), 64'(0));
    check("r9_count0", 64'(cnt[0]), 64'(0));

    // same-cycle writeback + issue to r4
    apply(0, 0, 0, 4, 4, 1, 4); tick();
    apply(1, 4, 32'h44, 4, 4, 1, 4);
    check("r4_nostall", 64'(stl[0]), 64'(0));
    tick();
    check("r4_count", 64'(cnt[0]), 64'(1));
    apply(0, 0, 0, 4, 4, 1, 0);
    check("r4_busy", 64'(rbsy[0][0]), 64'(1));
    tick();
    check("r0_issue_ignored", 64'(cnt[0]), 64'(1));
    apply(1, 4, 32'h45, 4, 4, 0, 0); tick();
    check("r4_count0", 64'(cnt[0]), 64'(0));

    // debug register and asynchronous reset mid-cycle
    apply(0, 0, 0, 3, 12, 1, 3); tick();
    apply(0, 0, 0, 3, 12, 1, 12); tick();
    apply(1, 3, 32'd42, 3, 12, 0, 0); tick();
    check("debug42", 64'(dbg[0]), 64'd42);
    apply(0, 0, 0, 3, 12, 0, 0);
    #1;
    ctrl_reset = 1'b1;
    #1;
    model_reset();
    check("mid_rst_rd", 64'(rd[0]), 64'(0));
    check("mid_rst_debug", 64'(dbg[0]), 64'(0));
    check("mid_rst_count", 64'(cnt[0]), 64'(0));
    check("mid_rst_busy", 64'(rbsy[0]), 64'(0));
    @(negedge clock);
    ctrl_reset = 1'b0;
    apply(1, 6, 32'h66, 6, 3, 1, 6); tick();

    // random traffic
    for (int n = 0; n < 10000; n++) begin
      apply(bit'($urandom_range(0, 1)), int'($urandom_range(0, 31)), DW'($urandom),
            int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
            bit'($urandom_range(0, 1)), int'($urandom_range(0, 31)));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
